beat_scheduler: RTL
===================

# beat_scheduler

Sequences the game's beat timing: loads a 20-bit beat period and a step count, runs a down-counter with a terminal-at-one detector, and emits one single-cycle `beat` strobe per step together with the step index. It sits between the song/menu control logic and the note-lane logic. A run can be paused, resumed and aborted, and `done` flags completion.

## Interface
- `PERIOD_W`, 20, width of beat period and counter
- `STEP_W`, 6, width of step count / step index
- `Clock`  in  1  single clock; all state updates on its rising edge
- `Reset`  in  1  synchronous, active-low reset
- `start`  in  1  request a run; sampled only in IDLE
- `pause`  in  1  level; holds the run while high
- `abort`  in  1  pulse; ends the run without `done`
- `period`  in  PERIOD_W  beat period in cycles; latched on accepted start
- `len`  in  STEP_W  number of beats in the run; latched on accepted start
- `beat`  out  1  one-cycle strobe per beat
- `step_idx`  out  STEP_W  index of the current/last beat, 0..len-1
- `busy`  out  1  high in RUN or PAUSE
- `done`  out  1  one-cycle strobe when the final beat is emitted

## Operation
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered or decoded from registered state.
- Reset (`Reset`=0 at an edge): state IDLE, counter 0, beats-emitted 0, `beat`=0, `done`=0, `busy`=0, `step_idx`=0. Reset overrides every input, in every state.
- IDLE: on `start`=1 and `len`!=0:
  - latch `period`; values 0 or 1 are clamped to 2
  - latch `len`; set counter = latched period; clear beats-emitted and `step_idx`; go to RUN
  - `start` with `len`=0 is ignored; the block stays in IDLE
- RUN, input priority per edge is abort > pause > count:
  - `abort`: go to IDLE, `beat`=0; `step_idx` is held
  - else `pause`: go to PAUSE; the counter is frozen on that edge
  - else if counter==1: reload counter with the period, set `beat`=1, set `step_idx` = beats-emitted, increment beats-emitted
    - if this is beat number len (step_idx = len-1), go to DONE
  - otherwise: decrement the counter, `beat`=0
- PAUSE: the counter is frozen and `beat`=0.
  - `abort` goes to IDLE
  - `pause`=0 goes to RUN; no decrement on the resume edge
- DONE: `done`=1 for exactly this one cycle; `busy`=0; the next edge goes to IDLE.
- `start` is ignored outside IDLE. Changes to `period` and `len` during a run have no effect.

## Timing
- A start accepted at edge 0 produces beats at edges P, 2P, … , len·P.
  - P is the latched (clamped) period.
  - `beat` is high for the cycle following each of those edges.
- The final beat and `done` are high in the same cycle. `busy` falls in that cycle.
- A new start is accepted at the earliest one edge after DONE, i.e. edge len·P+2.
- Each paused cycle delays all remaining beats by one cycle. So does the resume edge.
- `pause` in the same cycle as counter==1 defers that beat. The beat fires the first RUN edge after resume.
- `abort` and `pause` together: abort wins.
- Counter width arithmetic is PERIOD_W unsigned. The counter never wraps because the minimum reload is 2.

## Structure
- The shared package `ddr_pkg` holds:
  - the state enum (IDLE/RUN/PAUSE/DONE)
  - `PERIOD_W`
  - `MIN_PERIOD`=2
- One sub-module is natural: `beat_timer`.
  - Ports: `load`, `hold`, `period` → registered counter and `at_one` flag.
  - The FSM and step bookkeeping stay in `beat_scheduler`.

## Test plan
- Reset:
  - `Reset`=0 for 2 edges mid-RUN → IDLE; `beat`, `done`, `busy` and `step_idx` all 0 on the next cycle.
- Normal run:
  - start with period=4, len=3 at edge 0 → `beat` after edges 4, 8, 12 with `step_idx` 0, 1, 2
  - `done` after edge 12; IDLE after edge 13
- Clamp and ignore:
  - start with period=0, len=2 → beats after edges 2 and 4
  - start with len=0 → stays IDLE, `busy`=0
- Pause:
  - period=5, len=2; `pause` high for 3 cycles at edges 2..4 (leaving PAUSE at edge 5) → first beat after edge 9 instead of 5
- Pause coincident with counter==1:
  - the beat is deferred and fires after the first RUN edge following release
- Abort:
  - abort during PAUSE → IDLE, no `done`
  - `start` asserted during RUN → ignored; the beat schedule is unchanged

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and constants for the rhythm-game timing blocks.
package ddr_pkg;

    localparam int unsigned PERIOD_W   = 20;
    localparam int unsigned STEP_W     = 6;
    localparam int unsigned MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/beat_timer.sv
// Loadable down-counter with a registered terminal-at-one flag.
module beat_timer #(
    parameter int unsigned PERIOD_W = 20
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                load,
    input  logic                hold,
    input  logic [PERIOD_W-1:0] period,
    output logic                at_one
);

    logic [PERIOD_W-1:0] count_q, count_d;
    logic                at_one_q;

    // Load wins over hold; otherwise count down by one.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = period;
        end else if (!hold) begin
            count_d = count_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count_q  <= '0;
            at_one_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            at_one_q <= (count_d == PERIOD_W'(1));
        end
    end

    assign at_one = at_one_q;

endmodule

// File: rtl/beat_scheduler.sv
// Beat sequencer: emits one strobe per step of a run, with pause/abort control.
module beat_scheduler #(
    parameter int unsigned PERIOD_W = ddr_pkg::PERIOD_W,
    parameter int unsigned STEP_W   = ddr_pkg::STEP_W
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic                pause,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] period,
    input  logic [STEP_W-1:0]   len,
    output logic                beat,
    output logic [STEP_W-1:0]   step_idx,
    output logic                busy,
    output logic                done
);

    import ddr_pkg::*;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [STEP_W-1:0]   len_q, len_d;
    logic [STEP_W-1:0]   emitted_q, emitted_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                beat_q, beat_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic                tmr_load;
    logic                tmr_hold;
    logic [PERIOD_W-1:0] tmr_val;
    logic                at_one;
    logic [PERIOD_W-1:0] period_clamped;

    // Periods below the minimum would make the terminal-at-one detector miss.
    assign period_clamped = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;

    beat_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .Clock  (Clock),
        .Reset  (Reset),
        .load   (tmr_load),
        .hold   (tmr_hold),
        .period (tmr_val),
        .at_one (at_one)
    );

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        len_d     = len_q;
        emitted_d = emitted_q;
        step_d    = step_q;
        beat_d    = 1'b0;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_hold  = 1'b1;
        tmr_val   = period_q;

        case (state_q)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    period_d  = period_clamped;
                    len_d     = len;
                    emitted_d = '0;
                    step_d    = '0;
                    tmr_load  = 1'b1;
                    tmr_val   = period_clamped;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (at_one) begin
                    tmr_load  = 1'b1;
                    beat_d    = 1'b1;
                    step_d    = emitted_q;
                    emitted_d = emitted_q + STEP_W'(1);
                    if (emitted_q == (len_q - STEP_W'(1))) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    tmr_hold = 1'b0;
                end
            end
            ST_PAUSE: begin
                // Resume edge only changes state; counting restarts on the next edge.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            period_q  <= '0;
            len_q     <= '0;
            emitted_q <= '0;
            step_q    <= '0;
            beat_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            len_q     <= len_d;
            emitted_q <= emitted_d;
            step_q    <= step_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign beat     = beat_q;
    assign step_idx = step_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
